uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side byte buffer directly downstream of the UART receiver. Captures each
//  received byte together with its parity/frame error flags on a one-cycle strobe,
//  holds up to DEPTH entries, and presents them to the CPU through a registered read
//  port. Reports occupancy, a level interrupt and a sticky overrun flag.
// PARAMETERS
//  DATA_W   8    width of a received data byte
//  DEPTH    16   entries; must be a power of two, >= 2
//  AW       4    address width, log2(DEPTH)
//  THRESH   8    irq_thresh asserts while count >= THRESH; range 1..DEPTH
// PORTS
//  clk_uart    in   1         clock, same domain as the receiver
//  clr         in   1         synchronous active-high reset
//  wr_en       in   1         one-cycle strobe: receiver has a completed byte
//  wr_data     in   DATA_W    received byte, valid with wr_en
//  wr_perr     in   1         parity error for this byte, valid with wr_en
//  wr_ferr     in   1         frame (stop bit) error for this byte, valid with wr_en
//  rd_en       in   1         CPU read request, one entry per cycle asserted
//  rd_data     out  DATA_W    byte returned by the read
//  rd_perr     out  1         parity flag stored with rd_data
//  rd_ferr     out  1         frame flag stored with rd_data
//  rd_valid    out  1         one-cycle pulse: rd_data/rd_perr/rd_ferr are valid
//  count       out  AW+1      entries currently stored, 0..DEPTH
//  empty       out  1         count == 0
//  full        out  1         count == DEPTH
//  irq_thresh  out  1         count >= THRESH
//  overrun     out  1         sticky: a write was dropped because the FIFO was full
//  ovr_clr     in   1         clears overrun
// BEHAVIOUR
//  - Everything updates on posedge clk_uart. While clr=1: write/read pointers=0,
//    count=0, empty=1, full=0, irq_thresh=0, overrun=0, rd_valid=0, rd_data=0,
//    rd_perr=0, rd_ferr=0. Storage contents are not reset and not observable.
//  - Entry format {ferr, perr, data}, DATA_W+2 bits.
//  - Pointers are AW+1 bits and wrap naturally; empty when equal, full when the
//    address bits are equal and the MSBs differ. count = wr_ptr - rd_ptr (mod 2^(AW+1)).
//  - Write accepted = wr_en & (!full | rd_accept). Accepted: store at wr_ptr[AW-1:0],
//    wr_ptr++. Not accepted while wr_en=1: entry dropped, overrun<=1 next edge.
//  - Read accepted (rd_accept) = rd_en & !empty. Latency 1: on the edge after
//    acceptance rd_data/rd_perr/rd_ferr hold the entry at old rd_ptr, rd_valid=1, rd_ptr++.
//    rd_en while empty: ignored, rd_valid=0, rd_data holds last value.
//  - rd_valid is 0 in every cycle not following an accepted read; rd_data holds.
//  - Simultaneous accepted write and read: count unchanged. When full this frees one
//    slot and the write is accepted (no overrun). When empty the read is rejected;
//    the write is accepted (no same-cycle bypass), count becomes 1.
//  - overrun: set by a dropped write, cleared by ovr_clr; set wins if both same cycle.
//  - count/empty/full/irq_thresh are registered and reflect the state after the edge.
// STRUCTURE
//  - Shared package uart_pkg: UART_DATA_W=8, UART_FIFO_DEPTH=16, entry field offsets
//    (ENT_PERR=DATA_W, ENT_FERR=DATA_W+1).
//  - One sub-module: uart_fifo_ram, simple dual-port memory, DEPTH x (DATA_W+2),
//    synchronous write, registered read; top holds pointers, flags and control.
// TESTING
//  1 clr=1 then release -> empty=1, count=0, full=0, overrun=0, rd_valid=0, rd_data=0.
//  2 write 0xA5(perr=1), 0x3C(ferr=1); read twice -> rd_valid pulses, 0xA5/perr=1/ferr=0
//    then 0x3C/perr=0/ferr=1, each one cycle after its rd_en; then empty=1.
//  3 write 16 bytes 0x00..0x0F -> full=1, count=16, irq_thresh=1 from 8th write;
//    17th write 0xFF -> dropped, overrun=1; drain -> 0x00..0x0F in order, no 0xFF.
//  4 full FIFO, wr_en(0x55)+rd_en same cycle -> rd_data=oldest, count stays 16,
//    overrun stays 0; 0x55 read last.
//  5 run 40 write/read pairs with count wandering 0..16 -> pointer wrap, data in order;
//    rd_en on empty -> no rd_valid; ovr_clr with simultaneous dropped write -> overrun=1.
//  6 clr=1 mid-stream with count=5 -> next cycle count=0, empty=1, overrun=0, rd_valid=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: default widths, FIFO geometry
// and the bit layout of a stored receive entry {ferr, perr, data}.
package uart_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int UART_FIFO_DEPTH  = 16;
    localparam int UART_FIFO_AW     = $clog2(UART_FIFO_DEPTH);
    localparam int UART_FIFO_THRESH = 8;

    // Entry field offsets: data occupies [UART_DATA_W-1:0], flags sit above it
    localparam int ENT_PERR = UART_DATA_W;
    localparam int ENT_FERR = UART_DATA_W + 1;
    localparam int ENT_W    = UART_DATA_W + 2;

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port storage for the receive FIFO: synchronous write, registered
// read. A read and a write to the same address in one cycle returns the old
// contents, which the full-FIFO read+write case relies on.
module uart_fifo_ram #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_d;
    logic [WIDTH-1:0] rdata_q;

    // Storage write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Next read register value: load on read, otherwise hold the last entry
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    // Read output register, cleared by the synchronous reset
    always_ff @(posedge clk) begin
        if (clr) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver. Stores {ferr, perr, data}
// per received byte, returns entries one cycle after an accepted read, and
// reports registered occupancy, threshold interrupt and a sticky overrun flag.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = UART_FIFO_DEPTH,
    parameter int AW     = UART_FIFO_AW,
    parameter int THRESH = UART_FIFO_THRESH
) (
    input  logic              clk_uart,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_perr,
    input  logic              wr_ferr,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_perr,
    output logic              rd_ferr,
    output logic              rd_valid,
    output logic [AW:0]       count,
    output logic              empty,
    output logic              full,
    output logic              irq_thresh,
    output logic              overrun,
    input  logic              ovr_clr
);

    localparam int          EW       = DATA_W + 2;
    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] THRESH_C = (AW + 1)'(THRESH);

    logic [AW:0]   wr_ptr_d, wr_ptr_q;
    logic [AW:0]   rd_ptr_d, rd_ptr_q;
    logic [AW:0]   count_d, count_q;
    logic          empty_d, empty_q;
    logic          full_d, full_q;
    logic          irq_d, irq_q;
    logic          ovr_d, ovr_q;
    logic          rd_valid_d, rd_valid_q;

    logic          rd_accept;
    logic          wr_accept;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;

    assign wr_entry = {wr_ferr, wr_perr, wr_data};

    // Accept decisions and next-state pointers/flags. A read frees a slot in
    // the same cycle, so a full FIFO still accepts a write alongside a read;
    // an empty FIFO rejects the read, so there is no write-to-read bypass.
    always_comb begin
        rd_accept  = rd_en & ~empty_q;
        wr_accept  = wr_en & (~full_q | rd_accept);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        count_d    = wr_ptr_d - rd_ptr_d;
        empty_d    = (wr_ptr_d == rd_ptr_d);
        full_d     = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) &&
                     (wr_ptr_d[AW] != rd_ptr_d[AW]);
        irq_d      = (count_d >= THRESH_C);

        // Dropped write sets, ovr_clr clears; set takes priority
        ovr_d      = (ovr_q & ~ovr_clr) | (wr_en & ~wr_accept);
        rd_valid_d = rd_accept;
    end

    // Control and status registers with synchronous reset
    always_ff @(posedge clk_uart) begin
        if (clr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            irq_q      <= 1'b0;
            ovr_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            irq_q      <= irq_d;
            ovr_q      <= ovr_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    uart_fifo_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk_uart),
        .clr   (clr),
        .we    (wr_accept),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (wr_entry),
        .re    (rd_accept),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_entry)
    );

    assign rd_data    = rd_entry[DATA_W-1:0];
    assign rd_perr    = rd_entry[DATA_W];
    assign rd_ferr    = rd_entry[DATA_W+1];
    assign rd_valid   = rd_valid_q;
    assign count      = count_q;
    assign empty      = empty_q;
    assign full       = full_q;
    assign irq_thresh = irq_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus updates a queue-based model and
// pushes expected read entries; a monitor pops and compares on each rd_valid.
module tb_uart_rx_fifo;

    localparam int DW = 8;
    localparam int DP = 16;
    localparam int AWD = 4;
    localparam int TH = 8;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_perr = 1'b0;
    logic          wr_ferr = 1'b0;
    logic          rd_en = 1'b0;
    logic          ovr_clr = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_perr;
    logic          rd_ferr;
    logic          rd_valid;
    logic [AWD:0]  count;
    logic          empty;
    logic          full;
    logic          irq_thresh;
    logic          overrun;

    uart_rx_fifo #(
        .DATA_W (DW),
        .DEPTH  (DP),
        .AW     (AWD),
        .THRESH (TH)
    ) dut (
        .clk_uart   (clk),
        .clr        (clr),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_perr    (wr_perr),
        .wr_ferr    (wr_ferr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_perr    (rd_perr),
        .rd_ferr    (rd_ferr),
        .rd_valid   (rd_valid),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .irq_thresh (irq_thresh),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: contents as a plain queue of {ferr, perr, data}
    logic [DW+1:0] model_q[$];
    logic [DW+1:0] sb_q[$];
    logic [DW+1:0] last_rd = '0;
    logic          m_ovr = 1'b0;

    function automatic void chk(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every rd_valid pulse must match the oldest outstanding read
    always @(negedge clk) begin
        if (rd_valid) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd_valid_spurious: got rd_valid=1 with data 0x%0h expected no read at %0t",
                         rd_data, $time);
            end else begin
                logic [DW+1:0] e;
                e = sb_q.pop_front();
                chk("rd_entry", {rd_ferr, rd_perr, rd_data}, e);
            end
        end
    end

    // One clock of stimulus: model the edge, then compare status after it
    task automatic cycle(input logic c, input logic w, input logic [DW-1:0] d,
                         input logic pe, input logic fe, input logic r, input logic oc);
        bit rd_ok;
        bit wr_ok;
        clr = c; wr_en = w; wr_data = d; wr_perr = pe; wr_ferr = fe;
        rd_en = r; ovr_clr = oc;
        if (c) begin
            model_q.delete();
            m_ovr   = 1'b0;
            last_rd = '0;
        end else begin
            rd_ok = r && (model_q.size() > 0);
            wr_ok = w && ((model_q.size() < DP) || rd_ok);
            if (rd_ok) begin
                last_rd = model_q.pop_front();
                sb_q.push_back(last_rd);
            end
            if (wr_ok) model_q.push_back({fe, pe, d});
            if (w && !wr_ok) m_ovr = 1'b1;
            else if (oc) m_ovr = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("count", count, model_q.size());
        chk("empty", empty, model_q.size() == 0);
        chk("full", full, model_q.size() == DP);
        chk("irq_thresh", irq_thresh, model_q.size() >= TH);
        chk("overrun", overrun, m_ovr);
        chk("rd_hold", {rd_ferr, rd_perr, rd_data}, last_rd);
    endtask

    task automatic idle();
        cycle(0, 0, '0, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [DW-1:0] d, input logic pe, input logic fe);
        cycle(0, 1, d, pe, fe, 0, 0);
    endtask

    task automatic rd();
        cycle(0, 0, '0, 0, 0, 1, 0);
    endtask

    initial begin
        // 1: reset and release
        cycle(1, 0, '0, 0, 0, 0, 0);
        cycle(1, 1, 8'h77, 0, 0, 1, 0);
        idle();
        chk("rst_rd_valid", rd_valid, 0);

        // 2: two entries with flags, read back
        wr(8'hA5, 1, 0);
        wr(8'h3C, 0, 1);
        rd();
        rd();
        idle();
        idle();

        // 3: fill to full, drop a 17th write, drain in order
        for (int i = 0; i < 16; i++) wr(8'(i), i[0], i[1]);
        wr(8'hFF, 0, 0);
        for (int i = 0; i < 16; i++) rd();
        idle();
        rd();   // read on empty: no rd_valid

        // 4: full FIFO with simultaneous write and read
        cycle(0, 0, '0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) wr(8'(8'h80 + i), 0, 0);
        cycle(0, 1, 8'h55, 1, 1, 1, 0);
        for (int i = 0; i < 16; i++) rd();
        idle();

        // 5: random wandering traffic across pointer wrap
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 40; i++) begin
                int unsigned pw;
                pw = (ph % 2 == 0) ? 75 : 25;
                cycle(0, ($urandom_range(0, 99) < pw), 8'($urandom), 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 99) >= pw), 0);
            end
        end
        for (int i = 0; i < 20; i++) wr(8'($urandom), 0, 0);
        cycle(0, 1, 8'hEE, 0, 0, 0, 1);   // ovr_clr together with a dropped write
        cycle(0, 0, '0, 0, 0, 0, 1);      // plain clear
        for (int i = 0; i < 17; i++) rd();

        // 6: reset mid-stream with entries held
        for (int i = 0; i < 5; i++) wr(8'(8'h40 + i), 0, 0);
        wr(8'h11, 0, 0);
        rd();
        cycle(1, 1, 8'h22, 0, 0, 1, 0);
        chk("clr_rd_valid", rd_valid, 0);
        idle();

        // Long random run including occasional reset and overrun clears
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) < 2), 1'($urandom), 8'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 99) < 10));
        end
        idle();
        idle();
        @(negedge clk);
        chk("reads_outstanding", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
